quad_enc_filt: RTL

Parametrised successor quadrature decoder for motor/encoder feedback: synchroniser and glitch filter on A/B/index, 4x decode with multiplier, sticky fault, count preload, index capture/clear and windowed velocity measurement. Sits between encoder pins and the register/SPI interface, which reads count, index and velocity and writes load/clear controls.

---
 rtl/quad_enc_filt.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/quad_enc_filt.sv
// Quadrature encoder front end: input synchroniser and glitch filter, 4x decode
// with step multiplier, sticky fault, count preload, index capture/clear and
// windowed velocity measurement.
module quad_enc_filt #(
  parameter int COUNT_WIDTH = 64,
  parameter int MULT_WIDTH  = 8,
  parameter int FILTER_LEN  = 3,
  parameter int VEL_WIDTH   = 32,
  parameter int VEL_PERIOD  = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a,
  input  logic                          b,
  input  logic                          idx,
  input  logic [MULT_WIDTH-1:0]         multiplier,
  input  logic                          count_load,
  input  logic signed [COUNT_WIDTH-1:0] count_load_value,
  input  logic                          index_clear_en,
  input  logic                          fault_clear,
  output logic signed [COUNT_WIDTH-1:0] count,
  output logic                          faultn,
  output logic                          direction,
  output logic                          step_strobe,
  output logic signed [COUNT_WIDTH-1:0] index_count,
  output logic                          index_strobe,
  output logic signed [VEL_WIDTH-1:0]   velocity,
  output logic                          velocity_valid
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WCW = $clog2(VEL_PERIOD);
  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(VEL_PERIOD - 1);
  localparam logic signed [VEL_WIDTH-1:0] VEL_MAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic signed [VEL_WIDTH-1:0] VEL_MIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};
  localparam logic signed [VEL_WIDTH-1:0] VEL_ONE = VEL_WIDTH'(1);

  // bit 0 = A, bit 1 = B, bit 2 = index
  logic [2:0]     sync1, sync2, filt, prev;
  logic [FCW-1:0] fcnt [3];

  logic chg_a, chg_b, step_valid, illegal, step_up, idx_rise;
  logic signed [COUNT_WIDTH-1:0] mult_ext, step_delta, count_next;
  logic signed [VEL_WIDTH-1:0]   acc, acc_next;
  logic [WCW-1:0]                win;
  logic                          win_last;

  // Two-flop synchroniser, per-input stability filter and previous-state register
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      prev  <= '0;
      for (int unsigned i = 0; i < 3; i++) fcnt[i] <= '0;
    end else begin
      sync1 <= {idx, b, a};
      sync2 <= sync1;
      prev  <= filt;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] != filt[i]) begin
          if (fcnt[i] == FLT_LAST) begin
            filt[i] <= sync2[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + FCW'(1);
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  // Step/fault/index decode and next count with load > index clear > step priority
  always_comb begin
    chg_a      = filt[0] ^ prev[0];
    chg_b      = filt[1] ^ prev[1];
    step_valid = chg_a ^ chg_b;
    illegal    = chg_a & chg_b;
    step_up    = filt[0] ^ prev[1];
    idx_rise   = filt[2] & ~prev[2];
    mult_ext   = COUNT_WIDTH'(multiplier);
    step_delta = step_up ? mult_ext : -mult_ext;
    count_next = count;
    if (count_load)
      count_next = count_load_value;
    else if (idx_rise && index_clear_en)
      count_next = step_valid ? step_delta : '0;
    else if (step_valid)
      count_next = count + step_delta;
  end

  // Saturating +/-1 per step velocity accumulator
  always_comb begin
    acc_next = acc;
    win_last = (win == WIN_LAST);
    if (step_valid) begin
      if (step_up) begin
        if (acc != VEL_MAX) acc_next = acc + VEL_ONE;
      end else begin
        if (acc != VEL_MIN) acc_next = acc - VEL_ONE;
      end
    end
  end

  // Position count, direction, strobes, sticky fault and index capture
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      faultn       <= 1'b1;
      direction    <= 1'b0;
      step_strobe  <= 1'b0;
      index_count  <= '0;
      index_strobe <= 1'b0;
    end else begin
      count        <= count_next;
      step_strobe  <= step_valid;
      index_strobe <= idx_rise;
      if (step_valid) direction <= step_up;
      if (illegal)
        faultn <= 1'b0;
      else if (fault_clear)
        faultn <= 1'b1;
      if (idx_rise) index_count <= count;
    end
  end

  // Free-running velocity window; publishes the accumulator on the terminal cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      win            <= '0;
      acc            <= '0;
      velocity       <= '0;
      velocity_valid <= 1'b0;
    end else begin
      velocity_valid <= win_last;
      if (win_last) begin
        win      <= '0;
        acc      <= '0;
        velocity <= acc_next;
      end else begin
        win <= win + WCW'(1);
        acc <= acc_next;
      end
    end
  end

endmodule
